// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle mul/div sequencer.
// Holds op and ALU encodings plus the FSM state type.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage
// and the mul/div sequencer.
interface alu_muldiv_seq_if;
    import muldiv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows
// the shared ALU for one ADD or SUB per iteration.
module alu_muldiv_seq
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_muldiv_seq_if.slave   bus,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_carry
);

    state_e           state_q, state_d;
    md_op_e           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [XLEN-1:0]  rs;
    logic             take;
    logic             is_mul;

    assign is_mul         = (op_q == MD_MUL) || (op_q == MD_MULHU);
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    // HI/LO double as remainder/quotient during divide.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        rs       = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        take     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    op_d    = md_op_e'(bus.in_op);
                    b_d     = bus.in_b;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = bus.in_a;
                end
            end
            RUN: begin
                if (is_mul) begin
                    alu_a = hi_q;
                    alu_b = lo_q[0] ? b_q : '0;
                    hi_d  = {alu_carry, alu_result[XLEN-1:1]};
                    lo_d  = {alu_result[0], lo_q[XLEN-1:1]};
                end else begin
                    alu_ctrl = ALU_SUB;
                    alu_a    = rs;
                    alu_b    = b_q;
                    take     = alu_carry | hi_q[XLEN-1];
                    hi_d     = take ? alu_result : rs;
                    lo_d     = {lo_q[XLEN-2:0], take};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = DONE;
                    unique case (1'b1)
                        (op_q == MD_MUL),
                        (op_q == MD_DIVU): res_d = lo_d;
                        default:           res_d = hi_d;
                    endcase
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized scoreboard bench for alu_muldiv_seq with a behavioural
// ALU and a plain-arithmetic reference model.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic [32:0] alu_sum;

    alu_muldiv_seq_if bus();

    alu_muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    // Combinational ALU: ADD carry-out, SUB carry = no borrow.
    assign alu_sum = (alu_ctrl == 3'b001)
                   ? ({1'b0, alu_a} - {1'b0, alu_b})
                   : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_result = alu_sum[31:0];
    assign alu_carry  = (alu_ctrl == 3'b001) ? (alu_a >= alu_b)
                                             : alu_sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hold = 0;
    logic [31:0] expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=busy required=ready");
        end else begin
            acc_cyc      = cyc;
            bus.in_valid = 1'b1;
            bus.in_op    = op;
            bus.in_a     = a;
            bus.in_b     = b;
            expq.push_back(ref_op(op, a, b));
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            bus.in_op    = 2'($urandom);
        end
    endtask

    // Monitor owns out_ready and checks every handshake.
    initial begin : monitor
        logic        prev_v;
        logic        prev_rdy;
        logic        rdy;
        logic [31:0] prev_res;
        logic [31:0] exp;
        prev_v   = 1'b0;
        prev_rdy = 1'b0;
        prev_res = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (!prev_v)
                    chk("latency", 32'(cyc - acc_cyc), 32'd33);
                if (prev_v && !prev_rdy) begin
                    chk("hold_result", bus.out_result, prev_res);
                    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
                end
                if (hold > 0) begin
                    hold--;
                    rdy = 1'b0;
                end else begin
                    rdy = ($urandom_range(3) != 0);
                end
                bus.out_ready = rdy;
                if (rdy) begin
                    chk("pending", 32'(expq.size() > 0), 32'd1);
                    if (expq.size() > 0) begin
                        exp = expq.pop_front();
                        chk("result", bus.out_result, exp);
                    end
                end
                prev_v   = 1'b1;
                prev_rdy = rdy;
                prev_res = bus.out_result;
            end else begin
                if (prev_v && prev_rdy)
                    chk("idle_after", 32'(bus.in_ready), 32'd1);
                bus.out_ready = 1'b0;
                prev_v   = 1'b0;
                prev_rdy = 1'b0;
            end
        end
    end

    initial begin : stim
        int n;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        rst = 1'b1;

        do_req(2'd0, 32'd7, 32'd6);
        do_req(2'd0, 32'hFFFF_FFFF, 32'd2);
        do_req(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_req(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_req(2'd2, 32'd100, 32'd7);
        do_req(2'd3, 32'd100, 32'd7);
        do_req(2'd2, 32'h8000_0000, 32'd1);
        do_req(2'd2, 32'd1234, 32'd0);
        do_req(2'd3, 32'd1234, 32'd0);

        hold = 10;
        do_req(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        do_req(2'd3, 32'hDEAD_BEEF, 32'd97);

        // Abandon a divide part-way through its iterations.
        do_req(2'd2, 32'hFFFF_0000, 32'd3);
        repeat (15) @(negedge clk);
        rst = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        do_req(2'd0, 32'd3, 32'd5);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(7) == 0) b = 32'd0;
            if ($urandom_range(3) == 0) b = b & 32'hFF;
            if ($urandom_range(9) == 0) hold = $urandom_range(12);
            do_req(op, a, b);
        end

        n = 0;
        while (expq.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0",
                     expq.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
